// File: rtl/duty_ramp.sv
// Slew-rate-limited duty source for pwm8: walks duty toward a requested target
// by STEP every PERIODS_PER_STEP PWM periods, updating only at period boundaries.
module duty_ramp #(
    parameter int unsigned STEP             = 1,
    parameter int unsigned PERIODS_PER_STEP = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tgt_duty,
    input  logic       tgt_vld,
    input  logic       estop,
    output logic [7:0] duty,
    output logic       prd_end,
    output logic       busy,
    output logic       done
);

    localparam int unsigned PCNT_W = (PERIODS_PER_STEP > 1) ? $clog2(PERIODS_PER_STEP) : 1;
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PERIODS_PER_STEP - 1);
    localparam logic [8:0] STEP9 = 9'(STEP);
    localparam logic [7:0] STEP8 = 8'(STEP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_e;

    logic [7:0]        cnt_q,   cnt_d;
    logic [PCNT_W-1:0] pcnt_q,  pcnt_d;
    logic [7:0]        tgt_q,   tgt_d;
    logic [7:0]        duty_q,  duty_d;
    state_e            state_q, state_d;
    logic              done_q,  done_d;

    // Widened to 9 bits so the remaining gap is compared without wrap.
    function automatic logic [7:0] step_toward(input state_e dir,
                                               input logic [7:0] cur,
                                               input logic [7:0] tgt);
        logic [8:0] gap;
        logic [7:0] nxt;
        nxt = cur;
        if (dir == UP) begin
            gap = {1'b0, tgt} - {1'b0, cur};
            nxt = (gap <= STEP9) ? tgt : cur + STEP8;
        end else if (dir == DOWN) begin
            gap = {1'b0, cur} - {1'b0, tgt};
            nxt = (gap <= STEP9) ? tgt : cur - STEP8;
        end
        return nxt;
    endfunction

    function automatic state_e dir_for(input logic [7:0] tgt, input logic [7:0] cur);
        if (tgt > cur)      return UP;
        else if (tgt < cur) return DOWN;
        else                return IDLE;
    endfunction

    assign cnt_d   = cnt_q + 8'd1;
    assign prd_end = (cnt_q == 8'hFF);

    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latch).
        tgt_d   = tgt_q;
        duty_d  = duty_q;
        pcnt_d  = pcnt_q;
        state_d = state_q;
        done_d  = 1'b0;

        if (estop) begin
            tgt_d   = 8'd0;
            duty_d  = 8'd0;
            pcnt_d  = '0;
            state_d = IDLE;
        end else begin
            case (state_q)
                UP, DOWN: begin
                    if (prd_end) begin
                        if (pcnt_q == PCNT_LAST) begin
                            duty_d = step_toward(state_q, duty_q, tgt_q);
                            pcnt_d = '0;
                        end else begin
                            pcnt_d = pcnt_q + PCNT_W'(1);
                        end
                    end
                end
                default: pcnt_d = '0;
            endcase

            // A step on this edge uses the old target; direction follows the new one.
            if (tgt_vld) begin
                tgt_d  = tgt_duty;
                pcnt_d = '0;
            end

            state_d = dir_for(tgt_d, duty_d);
            done_d  = (state_q != IDLE) && (state_d == IDLE);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= 8'd0;
            pcnt_q  <= '0;
            tgt_q   <= 8'd0;
            duty_q  <= 8'd0;
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pcnt_q  <= pcnt_d;
            tgt_q   <= tgt_d;
            duty_q  <= duty_d;
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    assign duty = duty_q;
    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule
